hbm_write_engine: RTL and testbench

Per-column HBM write master for the CGRA data path. It accepts a write command (base address and beat count) plus a phit-wide result stream with per-lane valid bits, and emits AXI4 write bursts (AW/W/B) to one HBM pseudo-channel. It is the write-direction counterpart of the HBM read return path (rdata_HBM/tvalid_rdata_HBM) and consumes the column's awaddr_HBM.

---
 rtl/hbm_write_engine.sv | 166 ++++++++++++++++
 tb/tb_hbm_write_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hbm_write_engine.sv
// Per-column HBM write master. It splits a beat-count command into AXI4 write
// bursts that never cross a 4 KB page, streams phits through W and tracks B.

module hbm_wstrb_lane (
  input  logic        en,
  input  logic        vld,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic [3:0]  strb
);
  assign dout = en ? din : '0;
  assign strb = {4{en & vld}};
endmodule

module hbm_write_engine #(
  parameter int phit_size       = 512,
  parameter int SIMD_degree     = 16,
  parameter int dwidth_HBMadd   = 33,
  parameter int dwidth_len      = 16,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [dwidth_HBMadd-1:0]  cmd_addr,
  input  logic [dwidth_len-1:0]     cmd_len,
  input  logic [phit_size-1:0]      in_tdata,
  input  logic [SIMD_degree-1:0]    in_tvalid_lanes,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [dwidth_HBMadd-1:0]  m_awaddr,
  output logic [7:0]                m_awlen,
  output logic [2:0]                m_awsize,
  output logic [1:0]                m_awburst,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [phit_size-1:0]      m_wdata,
  output logic [phit_size/8-1:0]    m_wstrb,
  output logic                      m_wlast,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = (dwidth_len > 9) ? dwidth_len : 9;

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_DRAIN, S_DONE} state_t;
  typedef struct packed {
    logic [dwidth_HBMadd-1:0] addr;
    logic [dwidth_len-1:0]    remaining;
  } cmd_t;

  state_t        state, state_nxt;
  cmd_t          cur;
  logic [CW-1:0] burst, burst_q, beat_cnt;
  logic [OW-1:0] outstanding;
  logic [6:0]    beats_to_4k;
  logic          acc, aw_hs, w_hs, b_fire, b_dec, last_beat, w_act;

  logic [SIMD_degree-1:0][31:0] lane_din, lane_dout;
  logic [SIMD_degree-1:0][3:0]  lane_strb;

  assign cmd_ready = rst & (state == S_IDLE);
  assign acc       = cmd_valid & cmd_ready;
  assign w_act     = (state == S_W);
  assign last_beat = (beat_cnt == CW'(1));

  // Aligned address: beats left in the 4 KB page are 64 minus the beat slot.
  assign beats_to_4k = 7'd64 - {1'b0, cur.addr[11:6]};
  always_comb begin
    burst = CW'(MAX_BURST);
    if (CW'(beats_to_4k) < burst)   burst = CW'(beats_to_4k);
    if (CW'(cur.remaining) < burst) burst = CW'(cur.remaining);
  end

  assign m_awvalid = (state == S_AW) && (outstanding < OW'(MAX_OUTSTANDING));
  assign m_awaddr  = (state == S_AW) ? cur.addr : '0;
  assign m_awlen   = (state == S_AW) ? 8'(burst - CW'(1)) : 8'h0;
  assign m_awsize  = rst ? 3'b110 : 3'b000;
  assign m_awburst = rst ? 2'b01 : 2'b00;
  assign m_bready  = rst;

  assign m_wvalid = w_act & in_valid;
  assign in_ready = w_act & m_wready;
  assign m_wlast  = w_act & last_beat;

  assign aw_hs  = m_awvalid & m_awready;
  assign w_hs   = m_wvalid & m_wready;
  assign b_fire = m_bvalid & m_bready;
  assign b_dec  = b_fire & (outstanding != '0);

  assign lane_din = in_tdata;
  assign m_wdata  = lane_dout;
  assign m_wstrb  = lane_strb;

  for (genvar i = 0; i < SIMD_degree; i++) begin : g_lane
    hbm_wstrb_lane u_lane (
      .en   (w_act),
      .vld  (in_tvalid_lanes[i]),
      .din  (lane_din[i]),
      .dout (lane_dout[i]),
      .strb (lane_strb[i])
    );
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (acc) state_nxt = (cmd_len == '0 || cmd_addr[5:0] != 6'd0) ? S_DONE : S_AW;
      S_AW:    if (aw_hs) state_nxt = S_W;
      S_W:     if (w_hs && last_beat)
                 state_nxt = (cur.remaining != dwidth_len'(burst_q)) ? S_AW : S_DRAIN;
      S_DRAIN: if (outstanding == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cur         <= '0;
      burst_q     <= '0;
      beat_cnt    <= '0;
      outstanding <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == S_DONE);

      if (acc)                  busy <= 1'b1;
      else if (state == S_DONE) busy <= 1'b0;

      // A misaligned start is flagged at accept; otherwise accept clears.
      if (acc)                             err <= (cmd_addr[5:0] != 6'd0);
      else if (b_fire && m_bresp != 2'b00) err <= 1'b1;

      if (acc) begin
        cur.addr      <= cmd_addr;
        cur.remaining <= cmd_len;
      end else if (w_hs && last_beat) begin
        cur.addr      <= cur.addr + (dwidth_HBMadd'(burst_q) << 6);
        cur.remaining <= cur.remaining - dwidth_len'(burst_q);
      end

      if (aw_hs) begin
        burst_q  <= burst;
        beat_cnt <= burst;
      end else if (w_hs) begin
        beat_cnt <= beat_cnt - CW'(1);
      end

      if (aw_hs && !b_dec)      outstanding <= outstanding + OW'(1);
      else if (b_dec && !aw_hs) outstanding <= outstanding - OW'(1);
    end
  end
endmodule

// File: tb/tb_hbm_write_engine.sv
// Directed bench for hbm_write_engine: AXI slave model logs AW/W/B traffic,
// one linear initial block issues commands and asserts hand-computed results.

module tb_hbm_write_engine;
  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [32:0]  cmd_addr;
  logic [15:0]  cmd_len;
  logic [511:0] in_tdata;
  logic [15:0]  in_tvalid_lanes;
  logic         in_valid;
  logic         in_ready;
  logic [32:0]  m_awaddr;
  logic [7:0]   m_awlen;
  logic [2:0]   m_awsize;
  logic [1:0]   m_awburst;
  logic         m_awvalid;
  logic         m_awready;
  logic [511:0] m_wdata;
  logic [63:0]  m_wstrb;
  logic         m_wlast;
  logic         m_wvalid;
  logic         m_wready = 1'b1;
  logic [1:0]   m_bresp;
  logic         m_bvalid;
  logic         m_bready;
  logic         busy, done, err;

  int checks = 0;
  int failures = 0;

  // Slave model state and logs
  logic [32:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];
  logic        w_last_q[$];
  logic [31:0] w_data_q[$];
  logic [63:0] w_strb_q[$];
  int unsigned src_idx = 0;
  int          b_cnt = 0;
  int          pending_b = 0;
  int          done_cnt = 0;
  int          b_at_done = 0;
  logic        err_at_done = 1'b0;
  logic        b_en;
  logic        wr_toggle;
  int          err_b_idx;

  hbm_write_engine #(.MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .in_tdata(in_tdata), .in_tvalid_lanes(in_tvalid_lanes), .in_valid(in_valid), .in_ready(in_ready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign in_tdata = {16{src_idx}};
  assign m_bvalid = b_en && (pending_b != 0);
  assign m_bresp  = (b_cnt == err_b_idx) ? 2'b10 : 2'b00;

  always @(posedge clk) begin
    if (m_awvalid && m_awready) begin
      aw_addr_q.push_back(m_awaddr);
      aw_len_q.push_back(m_awlen);
    end
    if (m_wvalid && m_wready) begin
      w_last_q.push_back(m_wlast);
      w_data_q.push_back(m_wdata[31:0]);
      w_strb_q.push_back(m_wstrb);
    end
    if (in_valid && in_ready) src_idx <= src_idx + 1;
    if (m_bvalid && m_bready) b_cnt <= b_cnt + 1;
    pending_b <= pending_b + ((m_wvalid && m_wready && m_wlast) ? 1 : 0)
                           - ((m_bvalid && m_bready) ? 1 : 0);
    m_wready <= wr_toggle ? ~m_wready : 1'b1;
    if (done) begin
      done_cnt    <= done_cnt + 1;
      err_at_done <= err;
      b_at_done   <= b_cnt;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [32:0] a, input logic [15:0] l);
    int n = 0;
    @(negedge clk);
    cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    chk("cmd_accept", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 1000) begin @(negedge clk); n++; end
    chk(tag, 64'(done_cnt - d0), 64'd1);
    repeat (4) @(negedge clk);
    chk({tag, "_once"}, 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    int ab, wb, bb, n, nl, bad_d, bad_s, bad_l;
    logic [3:0] lp;
    rst = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    in_tvalid_lanes = 16'hFFFF; in_valid = 1'b1; m_awready = 1'b1;
    b_en = 1'b1; wr_toggle = 1'b0; err_b_idx = -1;

    // Reset state
    #1 chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("idle_flags", {59'd0, busy, done, err, m_awvalid, m_wvalid}, 64'd0);

    // 1: single aligned 16-beat burst
    ab = aw_addr_q.size(); wb = w_data_q.size(); bb = b_cnt;
    send_cmd(33'h0, 16'd16);
    wait_done("t1_done");
    chk("t1_aw_count", 64'(aw_addr_q.size() - ab), 64'd1);
    chk("t1_awaddr", 64'(aw_addr_q[ab]), 64'h0);
    chk("t1_awlen", 64'(aw_len_q[ab]), 64'd15);
    chk("t1_w_count", 64'(w_data_q.size() - wb), 64'd16);
    nl = 0;
    for (int i = 0; i < 16; i++) nl += int'(w_last_q[wb+i]);
    chk("t1_wlast_count", 64'(nl), 64'd1);
    chk("t1_wlast_pos", 64'(w_last_q[wb+15]), 64'd1);
    chk("t1_wstrb", w_strb_q[wb], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t1_b_before_done", 64'(b_at_done - bb), 64'd1);
    chk("t1_err", 64'(err_at_done), 64'd0);

    // 2: split at the 4 KB boundary
    ab = aw_addr_q.size(); wb = w_data_q.size();
    send_cmd(33'hFC0, 16'd4);
    wait_done("t2_done");
    chk("t2_aw_count", 64'(aw_addr_q.size() - ab), 64'd2);
    chk("t2_aw0", {aw_addr_q[ab], aw_len_q[ab]}, {33'hFC0, 8'd0});
    chk("t2_aw1", {aw_addr_q[ab+1], aw_len_q[ab+1]}, {33'h1000, 8'd2});
    chk("t2_w_count", 64'(w_data_q.size() - wb), 64'd4);
    lp = {w_last_q[wb+3], w_last_q[wb+2], w_last_q[wb+1], w_last_q[wb]};
    chk("t2_wlast_pattern", 64'(lp), 64'b1001);

    // 3: 40 beats with toggling wready and partial lane valids
    ab = aw_addr_q.size(); wb = w_data_q.size();
    wr_toggle = 1'b1; in_tvalid_lanes = 16'h0003;
    send_cmd(33'h2000, 16'd40);
    wait_done("t3_done");
    wr_toggle = 1'b0; in_tvalid_lanes = 16'hFFFF;
    chk("t3_aw_count", 64'(aw_addr_q.size() - ab), 64'd3);
    chk("t3_aw0", {aw_addr_q[ab], aw_len_q[ab]}, {33'h2000, 8'd15});
    chk("t3_aw1", {aw_addr_q[ab+1], aw_len_q[ab+1]}, {33'h2400, 8'd15});
    chk("t3_aw2", {aw_addr_q[ab+2], aw_len_q[ab+2]}, {33'h2800, 8'd7});
    chk("t3_w_count", 64'(w_data_q.size() - wb), 64'd40);
    bad_d = 0; bad_s = 0; bad_l = 0;
    for (int i = 0; i < 40; i++) begin
      if (w_data_q[wb+i] !== 32'(wb + i)) bad_d++;
      if (w_strb_q[wb+i] !== 64'hFF) bad_s++;
      if (w_last_q[wb+i] !== ((i == 15) || (i == 31) || (i == 39))) bad_l++;
    end
    chk("t3_data_order_bad", 64'(bad_d), 64'd0);
    chk("t3_wstrb_bad", 64'(bad_s), 64'd0);
    chk("t3_wlast_bad", 64'(bad_l), 64'd0);

    // 4: outstanding limit of 2 with B held off
    ab = aw_addr_q.size(); wb = w_data_q.size(); bb = b_cnt;
    b_en = 1'b0;
    send_cmd(33'h3000, 16'd48);
    repeat (80) @(negedge clk);
    chk("t4_aw_stalled", 64'(aw_addr_q.size() - ab), 64'd2);
    chk("t4_w_stalled", 64'(w_data_q.size() - wb), 64'd32);
    chk("t4_awvalid_low", 64'(m_awvalid), 64'd0);
    chk("t4_busy", 64'(busy), 64'd1);
    b_en = 1'b1;
    wait_done("t4_done");
    chk("t4_aw_count", 64'(aw_addr_q.size() - ab), 64'd3);
    chk("t4_aw2", {aw_addr_q[ab+2], aw_len_q[ab+2]}, {33'h3800, 8'd15});
    chk("t4_w_count", 64'(w_data_q.size() - wb), 64'd48);
    chk("t4_b_before_done", 64'(b_at_done - bb), 64'd3);

    // 5: error response on burst 2 of 3, then zero-length and misaligned
    err_b_idx = b_cnt + 1;
    send_cmd(33'h4000, 16'd40);
    wait_done("t5_done");
    err_b_idx = -1;
    chk("t5_err_at_done", 64'(err_at_done), 64'd1);
    chk("t5_err_sticky", 64'(err), 64'd1);
    ab = aw_addr_q.size(); wb = w_data_q.size();
    send_cmd(33'h5000, 16'd0);
    @(negedge clk);
    chk("t5_len0_cycle1", {61'd0, done, err, busy}, {61'd0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    chk("t5_len0_cycle2", {62'd0, done, busy}, {62'd0, 1'b1, 1'b0});
    repeat (3) @(negedge clk);
    chk("t5_len0_no_axi", 64'((aw_addr_q.size() - ab) + (w_data_q.size() - wb)), 64'd0);
    send_cmd(33'h20, 16'd4);
    wait_done("t5_misaligned_done");
    chk("t5_misaligned_err", 64'(err_at_done), 64'd1);
    chk("t5_misaligned_no_axi", 64'((aw_addr_q.size() - ab) + (w_data_q.size() - wb)), 64'd0);

    // 6: asynchronous reset in the middle of a W burst
    wb = w_data_q.size();
    send_cmd(33'h6000, 16'd16);
    n = 0;
    while (w_data_q.size() < wb + 3 && n < 100) begin @(negedge clk); n++; end
    chk("t6_w_started", 64'(w_data_q.size() >= wb + 3), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_ctrl_zero", {51'd0, cmd_ready, in_ready, m_awvalid, m_wvalid, m_wlast,
                             m_bready, busy, done, err, m_awsize, m_awburst == 2'b00 ? 1'b0 : 1'b1}, 64'd0);
    chk("t6_rst_data_zero", 64'(|{m_wdata, m_wstrb, m_awaddr, m_awlen}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_post_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("t6_post_outstanding", 64'(dut.outstanding), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
